string_uart_tx: RTL and testbench
=================================

Name: string_uart_tx

Overview:
- Downstream of the board-to-string renderer.
- Captures the 5000-bit display string when the renderer raises done, then streams it byte by byte to the host terminal as 8N1 UART serial.
- Leading and embedded NUL (0x00) bytes are skipped. The renderer's string is right-justified in the wide vector, so its upper bytes are zero padding.
- Drives the board's TX pin directly; includes its own baud timing.

Parameters:
- STR_BITS, 5000, width of display_string; must be a multiple of 8.
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); must be ≥ 2.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  capture request; sampled only in IDLE; connected to the renderer's done
- display_string  input  STR_BITS  ASCII text; first character in bits [STR_BITS-1:STR_BITS-8]
- busy  output  1  high from the cycle after start is accepted until the sent pulse (inclusive)
- sent  output  1  one-cycle pulse when the whole string has been processed
- tx  output  1  UART line; idles high
- chars_sent  output  $clog2(STR_BITS/8+1)  count of non-NUL bytes transmitted in the current/last string

Behaviour:
- Reset (async, rst_n=0) gives: tx=1, busy=0, sent=0, chars_sent=0, state IDLE. Shift register and counters are cleared.
- Reset mid-frame aborts immediately; tx returns high without completing the frame.
- States: IDLE, SCAN, START_BIT, DATA, STOP_BIT, DONE.
- IDLE:
  - start=1 at cycle N: copy display_string into shift register, byte_left=STR_BITS/8, chars_sent=0, go to SCAN.
  - busy=1 from N+1.
- SCAN, one cycle per examined byte:
  - byte_left==0: go to DONE.
  - Top byte ==0x00: shift left 8, byte_left-1, stay in SCAN.
  - Otherwise: latch top byte into tx_byte, shift left 8, byte_left-1, go to START_BIT.
- START_BIT / DATA / STOP_BIT:
  - Each bit is held on tx for exactly CLKS_PER_BIT cycles; the baud counter restarts on entry to START_BIT.
  - Data is sent LSB first, bits 0..7. Stop bit is 1.
  - Leaving STOP_BIT: chars_sent+1, return to SCAN.
- DONE: sent=1 for one cycle, busy=0 next cycle, go to IDLE.
- Latency:
  - If the first byte is non-NUL, tx falls at the edge after the SCAN cycle, i.e. tx=0 first visible in cycle N+2.
  - Each leading NUL adds 1 cycle.
- Gap between frames: ≥1 clk of tx=1 (one SCAN cycle, plus one per skipped NUL).
- Frame length is 10*CLKS_PER_BIT clocks.
- start while busy is ignored; no queuing. The captured string is unaffected by later display_string changes.
- start held high continuously: after DONE→IDLE, a new capture begins in the next cycle.
- All-zero string: no tx activity; sent pulses STR_BITS/8+1 cycles after acceptance.
- tx is registered; no combinational path from inputs to tx.

Optional Feature:
- UART_PARITY_EN:
  - Defined: an even-parity bit (XOR of the 8 data bits) is inserted between data bit 7 and the stop bit, held CLKS_PER_BIT cycles. State PARITY_BIT is added and the frame is 11*CLKS_PER_BIT.
  - Undefined: 8N1 as above; PARITY_BIT state does not exist.

Decomposition:
- Shared package string_uart_pkg holds:
  - state enum
  - constants UART_DATA_BITS=8, UART_IDLE_LEVEL=1'b1, NUL_CHAR=8'h00
- One sub-module, uart_baud_tick:
  - Counter 0..CLKS_PER_BIT-1 with synchronous restart input.
  - Outputs a one-cycle bit_done pulse on the last count.

Test Plan (CLKS_PER_BIT=4):
- Reset mid-DATA bit: assert rst_n=0 → tx=1, busy=0, chars_sent=0 in the same cycle; after release, start begins cleanly.
- String "A" (0x41, rest 0): start → 624 SCAN cycles, then tx = 0,1,0,0,0,0,0,1,0,1 each held 4 clk; sent pulse; chars_sent=1.
- Full rendered board (527 chars, 98 leading NUL bytes): chars_sent=527, decoded stream starts "-----" and ends "\n\r", sent exactly once.
- All-zero string: tx stays 1 throughout, sent at cycle N+626, chars_sent=0.
- start pulsed again while busy, with display_string changed: output matches the original capture; no second transmission.
- UART_PARITY_EN defined, byte 0x07: parity bit 1, frame 44 clk; byte 0x03: parity bit 0.

Source files
------------

// File: rtl/string_uart_pkg.sv
// Shared constants and FSM state encoding for string_uart_tx.
// Defining UART_PARITY_EN adds the even-parity bit state.
package string_uart_pkg;

  localparam int unsigned UART_DATA_BITS  = 8;
  localparam logic        UART_IDLE_LEVEL = 1'b1;
  localparam logic [7:0]  NUL_CHAR        = 8'h00;

  typedef logic [2:0] state_t;

  localparam state_t StIdle  = 3'd0;
  localparam state_t StScan  = 3'd1;
  localparam state_t StStart = 3'd2;
  localparam state_t StData  = 3'd3;
  localparam state_t StStop  = 3'd4;
  localparam state_t StDone  = 3'd5;
`ifdef UART_PARITY_EN
  localparam state_t StParity = 3'd6;
`endif

endpackage

// File: rtl/uart_baud_tick.sv
// Baud divider: counts 0..CLKS_PER_BIT-1, pulses bit_done on the last count.
module uart_baud_tick #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic bit_done
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    bit_done = !restart && (cnt_q == CntW'(CLKS_PER_BIT - 1));
    if (restart || bit_done) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/string_uart_tx.sv
// Captures the rendered display string and streams its non-NUL bytes as UART serial.
// Build option: define UART_PARITY_EN for an even-parity bit (8E1 frames).
module string_uart_tx
  import string_uart_pkg::*;
#(
  parameter int unsigned STR_BITS     = 5000,
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic [STR_BITS-1:0]                display_string,
  output logic                               busy,
  output logic                               sent,
  output logic                               tx,
  output logic [$clog2(STR_BITS/8+1)-1:0]    chars_sent
);

  localparam int unsigned NumBytes = STR_BITS / 8;
  localparam int unsigned CntW     = $clog2(NumBytes + 1);

  state_t              state_q, state_d;
  logic [STR_BITS-1:0] shreg_q, shreg_d;
  logic [CntW-1:0]     byte_left_q, byte_left_d;
  logic [CntW-1:0]     chars_q, chars_d;
  logic [7:0]          tx_byte_q, tx_byte_d;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic                tx_q, tx_d;
`ifdef UART_PARITY_EN
  logic                parity_q, parity_d;
`endif
  logic [7:0]          top_byte;
  logic                in_bit;
  logic                bit_done;

  assign top_byte   = shreg_q[STR_BITS-1 -: 8];
  assign busy       = (state_q != StIdle);
  assign sent       = (state_q == StDone);
  assign tx         = tx_q;
  assign chars_sent = chars_q;

  always_comb begin
    in_bit = (state_q == StStart) || (state_q == StData) || (state_q == StStop);
`ifdef UART_PARITY_EN
    in_bit = in_bit || (state_q == StParity);
`endif
  end

  // Held in restart outside the bit states, so the count is zero on entry to StStart.
  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (!in_bit),
    .bit_done(bit_done)
  );

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    byte_left_d = byte_left_q;
    chars_d     = chars_q;
    tx_byte_d   = tx_byte_q;
    bit_cnt_d   = bit_cnt_q;
    tx_d        = tx_q;
`ifdef UART_PARITY_EN
    parity_d    = parity_q;
`endif
    case (state_q)
      StIdle: begin
        if (start) begin
          shreg_d     = display_string;
          byte_left_d = CntW'(NumBytes);
          chars_d     = '0;
          state_d     = StScan;
        end
      end
      StScan: begin
        if (byte_left_q == '0) begin
          state_d = StDone;
        end else begin
          shreg_d     = shreg_q << 8;
          byte_left_d = byte_left_q - CntW'(1);
          if (top_byte != NUL_CHAR) begin
            tx_byte_d = top_byte;
`ifdef UART_PARITY_EN
            parity_d  = ^top_byte;
`endif
            tx_d      = 1'b0;
            state_d   = StStart;
          end else if (byte_left_q == CntW'(1)) begin
            // Trailing NUL: nothing left to examine, finish without an extra scan cycle.
            state_d = StDone;
          end
        end
      end
      StStart: begin
        if (bit_done) begin
          tx_d      = tx_byte_q[0];
          bit_cnt_d = '0;
          state_d   = StData;
        end
      end
      StData: begin
        if (bit_done) begin
          if (bit_cnt_q == 3'(UART_DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
            tx_d    = parity_q;
            state_d = StParity;
`else
            tx_d    = UART_IDLE_LEVEL;
            state_d = StStop;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            tx_byte_d = tx_byte_q >> 1;
            tx_d      = tx_byte_q[1];
          end
        end
      end
`ifdef UART_PARITY_EN
      StParity: begin
        if (bit_done) begin
          tx_d    = UART_IDLE_LEVEL;
          state_d = StStop;
        end
      end
`endif
      StStop: begin
        if (bit_done) begin
          chars_d = chars_q + CntW'(1);
          state_d = StScan;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        tx_d    = UART_IDLE_LEVEL;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      shreg_q     <= '0;
      byte_left_q <= '0;
      chars_q     <= '0;
      tx_byte_q   <= '0;
      bit_cnt_q   <= '0;
      tx_q        <= UART_IDLE_LEVEL;
`ifdef UART_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      byte_left_q <= byte_left_d;
      chars_q     <= chars_d;
      tx_byte_q   <= tx_byte_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_q        <= tx_d;
`ifdef UART_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_string_uart_tx.sv
// Self-checking bench for string_uart_tx: table of strings plus reset/busy/held-start sequences.
module tb_string_uart_tx;

  localparam int STR_BITS = 5000;
  localparam int CPB      = 4;
`ifdef UART_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME = FRAME_BITS * CPB;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                start = 1'b0;
  logic [STR_BITS-1:0] display_string = '0;
  logic                busy, sent, tx;
  logic [9:0]          chars_sent;

  string_uart_tx #(
    .STR_BITS    (STR_BITS),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .display_string(display_string),
    .busy          (busy),
    .sent          (sent),
    .tx            (tx),
    .chars_sent    (chars_sent)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Line monitor: frame decoder, sent counter and first-start-bit timestamp.
  int                    n0 = 0;
  int                    first_low = -1;
  int                    sent_count = 0;
  int                    sent_at = -1;
  int                    frm_err = 0;
  logic [7:0]            rx_q[$];
  bit                    in_frame = 1'b0;
  int                    j = 0;
  logic                  cur = 1'b1;
  logic [FRAME_BITS-1:0] bits = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_frame = 1'b0;
    end else begin
      if (sent) begin
        sent_count++;
        sent_at = cyc - n0;
      end
      if (!in_frame && tx == 1'b0) begin
        in_frame = 1'b1;
        j = 0;
        if (first_low < 0) first_low = cyc - n0;
      end
      if (in_frame) begin
        if (j % CPB == 0) cur = tx;
        else if (tx !== cur) frm_err++;
        if (j % CPB == CPB - 1) bits[j / CPB] = cur;
        j++;
        if (j == FRAME) begin
          in_frame = 1'b0;
          if (bits[0] !== 1'b0 || bits[FRAME_BITS-1] !== 1'b1) frm_err++;
`ifdef UART_PARITY_EN
          if (bits[9] !== ^bits[8:1]) frm_err++;
`endif
          rx_q.push_back(bits[8:1]);
        end
      end
    end
  end

  task automatic clear_mon();
    first_low  = -1;
    sent_count = 0;
    sent_at    = -1;
    frm_err    = 0;
    rx_q.delete();
  endtask

  function automatic logic [STR_BITS-1:0] mk(input logic [63:0] text, input int len,
                                             input int lead);
    logic [STR_BITS-1:0] s;
    s = '0;
    for (int i = 0; i < len; i++) s[STR_BITS-1-8*(lead+i) -: 8] = text[8*(len-1-i) +: 8];
    return s;
  endfunction

  task automatic wait_sent(input int want, input int bound);
    int k;
    k = 0;
    while (sent_count < want && k < bound) begin
      @(negedge clk);
      k++;
    end
    if (sent_count < want) $display("FAIL sent_timeout: got %0d pulses, expected %0d", sent_count, want);
  endtask

  // Runs one string through the DUT and checks it against the reference byte list.
  task automatic run_string(input string name, input logic [STR_BITS-1:0] s, input int exp_chars,
                            input int exp_first, input int exp_sent);
    logic [7:0] exp_q[$];
    int bad;
    for (int b = 0; b < STR_BITS / 8; b++) begin
      if (s[STR_BITS-1-8*b -: 8] != 8'h00) exp_q.push_back(s[STR_BITS-1-8*b -: 8]);
    end
    clear_mon();
    @(negedge clk);
    display_string = s;
    start = 1'b1;
    n0 = cyc;
    @(negedge clk);
    start = 1'b0;
    check({name, "_busy_accept"}, busy, 1);
    wait_sent(1, 30000);
    repeat (4) @(negedge clk);
    check({name, "_sent_count"}, sent_count, 1);
    check({name, "_sent_cycle"}, sent_at, exp_sent);
    check({name, "_first_start_bit"}, first_low, exp_first);
    check({name, "_chars_sent"}, chars_sent, exp_chars);
    check({name, "_rx_count"}, rx_q.size(), exp_q.size());
    bad = 0;
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) if (rx_q[i] != exp_q[i]) bad++;
    check({name, "_rx_bytes_wrong"}, bad, 0);
    check({name, "_frame_errors"}, frm_err, 0);
    check({name, "_busy_idle"}, busy, 0);
  endtask

  typedef struct {
    logic [63:0] text;
    int          len;
    int          lead;
    int          exp_chars;
    int          exp_first;
    int          exp_sent;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [STR_BITS-1:0] board;
    logic [7:0]          c;

    vecs[0] = '{64'h41,     1, 624, 1, 626, 626 + FRAME + 1};      // "A" right-justified
    vecs[1] = '{64'h0,      0, 0,   0, -1,  626};                  // all zero
    vecs[2] = '{64'h41,     1, 0,   1, 2,   626 + FRAME};          // "A" first, NULs trail
    vecs[3] = '{64'h480069, 3, 0,   2, 2,   626 + 2 * FRAME};      // "H", NUL, "i"
    vecs[4] = '{64'h0A0D,   2, 623, 2, 625, 626 + 2 * FRAME + 1};  // "\n\r" at the end

    repeat (3) @(negedge clk);
    check("reset_tx", tx, 1);
    check("reset_busy", busy, 0);
    check("reset_sent", sent, 0);
    check("reset_chars", chars_sent, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Reset during data bit 1 of 'A' (a 0 bit) must release the line at once.
    clear_mon();
    display_string = mk(64'h41, 1, 0);
    start = 1'b1;
    n0 = cyc;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("midframe_tx_low", tx, 0);
    rst_n = 1'b0;
    #1;
    check("midreset_tx", tx, 1);
    check("midreset_busy", busy, 0);
    check("midreset_chars", chars_sent, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 5; v++) begin
      run_string($sformatf("vec%0d", v), mk(vecs[v].text, vecs[v].len, vecs[v].lead),
                 vecs[v].exp_chars, vecs[v].exp_first, vecs[v].exp_sent);
    end

    // Full board: 98 leading NULs, 527 characters "-----...\n\r".
    board = '0;
    for (int i = 0; i < 527; i++) begin
      if (i < 5) c = 8'h2D;
      else if (i == 525) c = 8'h0A;
      else if (i == 526) c = 8'h0D;
      else c = 8'h61 + 8'(i % 26);
      board[STR_BITS-1-8*(98+i) -: 8] = c;
    end
    run_string("board", board, 527, 100, 626 + 527 * FRAME + 1);

    // Second start while busy with a new string must be ignored.
    clear_mon();
    @(negedge clk);
    display_string = mk(64'h41, 1, 0);
    start = 1'b1;
    n0 = cyc;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    display_string = mk(64'h5A, 1, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_sent(1, 3000);
    repeat (60) @(negedge clk);
    check("busy_start_rx_count", rx_q.size(), 1);
    check("busy_start_byte", (rx_q.size() > 0) ? rx_q[0] : 8'hFF, 8'h41);
    check("busy_start_sent_count", sent_count, 1);
    check("busy_start_sent_cycle", sent_at, 626 + FRAME);
    check("busy_start_chars", chars_sent, 1);

    // start held high: the next capture follows DONE->IDLE immediately.
    clear_mon();
    @(negedge clk);
    display_string = '0;
    start = 1'b1;
    n0 = cyc;
    wait_sent(2, 3000);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("held_sent_count", sent_count, 2);
    check("held_second_sent_cycle", sent_at, 1253);
    check("held_no_tx", first_low, -1);
    check("held_busy_idle", busy, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
